// File: rtl/camera_load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : camera_load_pkg
// Description : Shared definitions for the camera frame reader: frame slot
//               base-address table, slot legality check, frame geometry and
//               FSM state encodings. The frame writer uses the same table.
// Revision    : 1.0 - initial release
// ============================================================================
package camera_load_pkg;

    // One 640x480 frame occupies 0x4B000 address units in DDR.
    localparam int unsigned c_frame_words      = 32'h0004_B000;
    localparam int unsigned c_addr_step        = 8;
    localparam int unsigned c_bursts_per_frame = c_frame_words / c_addr_step;

    // Reader FSM state encodings
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_req   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    // Frame slot code to DDR base address. Codes 011 and 111 are unused.
    function automatic logic [31:0] frame_base(input logic [2:0] sel);
        logic [31:0] v;
        v = 32'h0000_0000;
        case (sel)
            3'b000:  v = 32'h0000_0000;
            3'b001:  v = 32'h0004_B000;
            3'b101:  v = 32'h0009_6000;
            3'b100:  v = 32'h000E_1000;
            3'b110:  v = 32'h0012_C000;
            3'b010:  v = 32'h0017_7000;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    function automatic logic frame_sel_legal(input logic [2:0] sel);
        return (sel != 3'b011) && (sel != 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/camera_load_if.sv
`default_nettype none
// ============================================================================
// Module      : camera_load_if
// Description : Bus bundle of the camera frame reader.
//               Read request side  : rd_address, rd_req, rd_ack,
//                                    rd_data, rd_data_valid
//               Stream output side : out_data, out_valid, out_ready
//               master = reader, slave = arbiter / consumer environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface camera_load_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 27
);
    logic [ADDR_W-1:0] rd_address;
    logic              rd_req;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output rd_address,
        output rd_req,
        input  rd_ack,
        input  rd_data,
        input  rd_data_valid,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  rd_address,
        input  rd_req,
        output rd_ack,
        output rd_data,
        output rd_data_valid,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/camera_load_fifo.sv
`default_nettype none
// ============================================================================
// Module      : camera_load_fifo
// Description : Single-clock first-word-fall-through FIFO. Written data is
//               visible at o_data the cycle after the push edge. A push while
//               full is accepted only when a pop happens on the same edge.
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : write i_data (ignored when full without a pop)
//   i_pop     : consume head (ignored when empty)
//   o_data    : head word
//   o_full, o_empty, o_count : occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module camera_load_fifo #(
    parameter int N    = 128,
    parameter int ADDR = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic [N-1:0]    i_data,
    input  logic            i_pop,
    output logic [N-1:0]    o_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [ADDR:0]   o_count
);
    localparam int           c_depth     = 1 << ADDR;
    localparam logic [ADDR:0] c_depth_cnt = {1'b1, {ADDR{1'b0}}};

    logic [N-1:0]    r_mem [0:c_depth-1];
    logic [ADDR-1:0] r_wr_ptr;
    logic [ADDR-1:0] r_rd_ptr;
    logic [ADDR:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == c_depth_cnt);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // When full, the slot being written is the one the pop frees this edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (ADDR+1)'(1);
                2'b01:   r_count <= r_count - (ADDR+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/camera_load.sv
`default_nettype none
// ============================================================================
// Module      : camera_load
// Description : Fetches one stored 640x480 frame from DDR. Issues one read
//               request per ADDR_STEP addresses, buffers returned words in a
//               local FWFT FIFO and streams them out with valid/ready.
//               Requests are credit-limited so returns never overflow the FIFO.
//   ui_clk, ui_rst       : sole clock, synchronous active-high reset
//   init_calib_complete  : DDR ready; frame_start ignored while low
//   frame_start/frame_sel: 1-cycle start pulse and frame slot code
//   bus (master)         : rd_* request/return and out_* stream signals
//   frame_busy           : fetch in progress
//   frame_done           : 1-cycle pulse once all frame data returned
//   err                  : sticky, spurious return or push into full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module camera_load
    import camera_load_pkg::*;
#(
    parameter int DATA_W           = 128,
    parameter int ADDR_W           = 27,
    parameter int FIFO_ADDR        = 6,
    parameter int MAX_OUTSTANDING  = 8,
    parameter int BURSTS_PER_FRAME = c_bursts_per_frame,
    parameter int ADDR_STEP        = c_addr_step
) (
    input  logic                ui_clk,
    input  logic                ui_rst,
    input  logic                init_calib_complete,
    input  logic                frame_start,
    input  logic [2:0]          frame_sel,
    camera_load_if.master       bus,
    output logic                frame_busy,
    output logic                frame_done,
    output logic                err
);
    localparam int c_out_w   = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_burst_w = $clog2(BURSTS_PER_FRAME + 1);
    localparam int c_sum_w   = FIFO_ADDR + 2;

    localparam logic [c_out_w-1:0]   c_max_out    = c_out_w'(MAX_OUTSTANDING);
    localparam logic [c_sum_w-1:0]   c_depth_sum  = c_sum_w'(1 << FIFO_ADDR);
    localparam logic [c_burst_w-1:0] c_last_burst = c_burst_w'(BURSTS_PER_FRAME - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [ADDR_W-1:0]    r_rd_address;
    logic [c_burst_w-1:0] r_burst_cnt;
    logic [c_out_w-1:0]   r_outstanding;
    logic                 r_err;

    logic                 w_rd_req;
    logic                 w_credit_ok;
    logic [c_sum_w-1:0]   w_credit_sum;
    logic                 w_start_ok;
    logic                 w_load;
    logic                 w_ack;
    logic                 w_last_ack;
    logic                 w_ret_ok;
    logic                 w_spurious;
    logic                 w_pop;
    logic                 w_overflow;

    logic [FIFO_ADDR:0]   w_fifo_count;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    // ------------------------------------------------------------------
    // Credit: every acked read owns a FIFO slot until it is popped, so
    // occupancy plus in-flight reads may never exceed the FIFO depth.
    // Without an ack this sum cannot grow (a return moves one unit from
    // outstanding into the FIFO), so rd_req never drops while unacked.
    // ------------------------------------------------------------------
    assign w_credit_sum = {1'b0, w_fifo_count} + c_sum_w'(r_outstanding);
    assign w_credit_ok  = (w_credit_sum < c_depth_sum) && (r_outstanding < c_max_out);

    assign w_start_ok = frame_start && init_calib_complete && frame_sel_legal(frame_sel);
    assign w_load     = (r_state == c_st_idle) && (w_state_next == c_st_req);
    assign w_ack      = w_rd_req && bus.rd_ack;
    assign w_last_ack = w_ack && (r_burst_cnt == c_last_burst);

    // Returns with nothing in flight (including stale returns after a reset)
    // are dropped and flagged.
    assign w_ret_ok   = bus.rd_data_valid && (r_outstanding != '0);
    assign w_spurious = bus.rd_data_valid && (r_outstanding == '0);
    assign w_pop      = !w_fifo_empty && bus.out_ready;
    assign w_overflow = w_ret_ok && w_fifo_full && !w_pop;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_req     = 1'b0;
        frame_busy   = 1'b0;
        frame_done   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_start_ok) begin
                    w_state_next = c_st_req;
                end
            end
            c_st_req: begin
                frame_busy = 1'b1;
                w_rd_req   = w_credit_ok;
                if (w_last_ack) begin
                    w_state_next = c_st_drain;
                end
            end
            c_st_drain: begin
                frame_busy = 1'b1;
                if (r_outstanding == '0) begin
                    frame_done   = 1'b1;
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address / burst / in-flight tracking and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            r_rd_address  <= '0;
            r_burst_cnt   <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_load) begin
                r_rd_address <= ADDR_W'(frame_base(frame_sel));
                r_burst_cnt  <= '0;
            end else if (w_ack) begin
                r_rd_address <= r_rd_address + ADDR_W'(ADDR_STEP);
                r_burst_cnt  <= r_burst_cnt + c_burst_w'(1);
            end

            case ({w_ack, w_ret_ok})
                2'b10:   r_outstanding <= r_outstanding + c_out_w'(1);
                2'b01:   r_outstanding <= r_outstanding - c_out_w'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_spurious || w_overflow) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Return buffer
    // ------------------------------------------------------------------
    camera_load_fifo #(
        .N    (DATA_W),
        .ADDR (FIFO_ADDR)
    ) u_fifo (
        .clk     (ui_clk),
        .rst     (ui_rst),
        .i_push  (w_ret_ok),
        .i_data  (bus.rd_data),
        .i_pop   (w_pop),
        .o_data  (bus.out_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign bus.rd_req     = w_rd_req;
    assign bus.rd_address = r_rd_address;
    assign bus.out_valid  = !w_fifo_empty;
    assign err            = r_err;
endmodule
`default_nettype wire

// File: tb/tb_camera_load.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_load
// Description : Directed self-checking bench for camera_load. A behavioural
//               arbiter acks requests immediately and returns data a fixed
//               number of cycles later; a consumer checks stream order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_load;

    logic       ui_clk = 1'b0;
    logic       ui_rst = 1'b1;
    logic       init_calib_complete = 1'b0;
    logic       frame_start = 1'b0;
    logic [2:0] frame_sel = 3'b000;
    logic       frame_busy;
    logic       frame_done;
    logic       err;

    camera_load_if #(.DATA_W(128), .ADDR_W(27)) bus ();

    camera_load dut (
        .ui_clk              (ui_clk),
        .ui_rst              (ui_rst),
        .init_calib_complete (init_calib_complete),
        .frame_start         (frame_start),
        .frame_sel           (frame_sel),
        .bus                 (bus),
        .frame_busy          (frame_busy),
        .frame_done          (frame_done),
        .err                 (err)
    );

    always #5 ui_clk = ~ui_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_data(input logic [26:0] a);
        return {5'd0, a, ~{5'd0, a}, 5'd0, a ^ 27'h5A5A5A5, 32'h1234_5678};
    endfunction

    // ---------------------------------------------------------------
    // Arbiter / memory model
    // ---------------------------------------------------------------
    typedef struct {
        int unsigned due;
        logic [26:0] addr;
    } pend_t;

    pend_t       pend_q[$];
    logic        ack_en = 1'b1;
    int unsigned delay = 4;
    int unsigned cyc = 0;
    int unsigned ack_cnt = 0;
    int unsigned ret_cnt = 0;
    int unsigned sim_cnt = 0;
    int unsigned addr_err = 0;
    int          tb_out = 0;
    logic [26:0] last_addr = '0;
    logic        chk_on = 1'b0;
    logic [26:0] chk_base = '0;
    int unsigned chk_ack0 = 0;
    int unsigned chk_pop0 = 0;
    logic        spur_req = 1'b0;
    logic        a_now;
    logic        vld;

    assign bus.rd_ack = bus.rd_req & ack_en;

    // Runs after each edge: decides what happens at the next edge.
    always @(posedge ui_clk) begin
        #2;
        cyc++;
        if (ui_rst) begin
            pend_q.delete();
            tb_out = 0;
            bus.rd_data_valid = 1'b0;
            bus.rd_data = '0;
        end else begin
            a_now = bus.rd_req && bus.rd_ack;
            vld   = 1'b0;
            if (spur_req) begin
                vld = 1'b1;
                bus.rd_data = '1;
            end else if (pend_q.size() > 0 && pend_q[0].due == cyc + 1) begin
                vld = 1'b1;
                bus.rd_data = mk_data(pend_q[0].addr);
                void'(pend_q.pop_front());
            end
            bus.rd_data_valid = vld;
            if (a_now) begin
                if (chk_on && bus.rd_address !== chk_base + 27'(8 * (ack_cnt - chk_ack0)))
                    addr_err++;
                last_addr = bus.rd_address;
                pend_q.push_back('{due: cyc + 1 + delay, addr: bus.rd_address});
                ack_cnt++;
            end
            if (vld && !spur_req) ret_cnt++;
            if (a_now && vld && !spur_req) sim_cnt++;
            tb_out = tb_out + (a_now ? 1 : 0) - ((vld && !spur_req) ? 1 : 0);
        end
    end

    // ---------------------------------------------------------------
    // Consumer model
    // ---------------------------------------------------------------
    int unsigned pop_cnt = 0;
    int unsigned pop_err = 0;
    int unsigned done_cnt = 0;
    int unsigned done_at_ret = 0;

    always @(negedge ui_clk) begin
        #1;
        if (!ui_rst && bus.out_valid && bus.out_ready) begin
            if (chk_on && bus.out_data !== mk_data(chk_base + 27'(8 * (pop_cnt - chk_pop0))))
                pop_err++;
            pop_cnt++;
        end
        if (frame_done) begin
            done_cnt++;
            done_at_ret = ret_cnt;
        end
    end

    task automatic pulse_start(input logic [2:0] sel);
        frame_sel   = sel;
        frame_start = 1'b1;
        @(negedge ui_clk);
        frame_start = 1'b0;
    endtask

    // ---------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------
    int unsigned d0, r0, a0, s0;
    int          mx;
    logic        got;

    initial begin
        bus.out_ready = 1'b0;
        repeat (3) @(negedge ui_clk);
        check("rst_rd_req",     128'(bus.rd_req),     128'(0));
        check("rst_rd_address", 128'(bus.rd_address), 128'(0));
        check("rst_out_valid",  128'(bus.out_valid),  128'(0));
        check("rst_busy",       128'(frame_busy),     128'(0));
        check("rst_done",       128'(frame_done),     128'(0));
        check("rst_err",        128'(err),            128'(0));
        ui_rst = 1'b0;
        @(negedge ui_clk);

        // Starts that must be ignored
        pulse_start(3'b001);
        check("calib_low_req",  128'(bus.rd_req), 128'(0));
        check("calib_low_busy", 128'(frame_busy), 128'(0));
        init_calib_complete = 1'b1;
        pulse_start(3'b011);
        check("sel011_req",  128'(bus.rd_req), 128'(0));
        check("sel011_busy", 128'(frame_busy), 128'(0));
        pulse_start(3'b111);
        check("sel111_busy", 128'(frame_busy), 128'(0));

        // Full frame, slot 001, consumer initially stalled
        chk_base = 27'h4B000;
        chk_ack0 = ack_cnt;
        chk_pop0 = pop_cnt;
        chk_on   = 1'b1;
        d0 = done_cnt;
        r0 = ret_cnt;
        pulse_start(3'b001);
        check("start_rd_req", 128'(bus.rd_req),     128'(1));
        check("start_addr",   128'(bus.rd_address), 128'(27'h4B000));
        check("start_busy",   128'(frame_busy),     128'(1));

        repeat (200) @(negedge ui_clk);
        check("stall_acks",      128'(ack_cnt - chk_ack0), 128'(64));
        check("stall_rd_req",    128'(bus.rd_req),         128'(0));
        check("stall_err",       128'(err),                128'(0));
        check("stall_out_valid", 128'(bus.out_valid),      128'(1));

        pulse_start(3'b000);
        check("busy_restart_busy", 128'(frame_busy), 128'(1));
        check("busy_restart_req",  128'(bus.rd_req), 128'(0));

        bus.out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50000 && !got; i++) begin
            @(negedge ui_clk);
            if (done_cnt != d0) got = 1'b1;
        end
        check("frame_done_seen", 128'(got), 128'(1));
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge ui_clk);
            if (!bus.out_valid) got = 1'b1;
        end
        check("fifo_drained", 128'(got), 128'(1));
        repeat (2) @(negedge ui_clk);
        check("total_acks",     128'(ack_cnt - chk_ack0), 128'(38400));
        check("last_addr",      128'(last_addr),          128'(27'h95FF8));
        check("addr_seq_err",   128'(addr_err),           128'(0));
        check("total_pops",     128'(pop_cnt - chk_pop0), 128'(38400));
        check("data_order_err", 128'(pop_err),            128'(0));
        check("done_count",     128'(done_cnt - d0),      128'(1));
        check("done_after_ret", 128'(done_at_ret - r0),   128'(38400));
        check("frame_err",      128'(err),                128'(0));
        check("idle_busy",      128'(frame_busy),         128'(0));
        chk_on = 1'b0;

        // Slow returns: in-flight count saturates at 8
        delay = 20;
        a0 = ack_cnt;
        s0 = sim_cnt;
        mx = 0;
        pulse_start(3'b010);
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge ui_clk);
            if (tb_out > mx) mx = tb_out;
            if (ack_cnt - a0 >= 100) got = 1'b1;
        end
        check("slow_reach_100",  128'(got),            128'(1));
        check("slow_max_out",    128'(mx),             128'(8));
        check("slow_ack_and_ret", 128'(sim_cnt != s0), 128'(1));
        check("slow_err",        128'(err),            128'(0));

        // Reset mid-frame
        bus.out_ready = 1'b0;
        repeat (25) @(negedge ui_clk);
        check("prerst_out_valid", 128'(bus.out_valid), 128'(1));
        ui_rst = 1'b1;
        @(negedge ui_clk);
        check("midrst_rd_req",    128'(bus.rd_req),    128'(0));
        check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        check("midrst_busy",      128'(frame_busy),    128'(0));
        check("midrst_err",       128'(err),           128'(0));
        ui_rst = 1'b0;
        delay = 4;
        @(negedge ui_clk);
        pulse_start(3'b000);
        check("restart_rd_req", 128'(bus.rd_req),     128'(1));
        check("restart_addr",   128'(bus.rd_address), 128'(0));
        repeat (10) @(negedge ui_clk);

        // Spurious return while idle
        ui_rst = 1'b1;
        @(negedge ui_clk);
        ui_rst = 1'b0;
        @(negedge ui_clk);
        check("pre_spur_err", 128'(err), 128'(0));
        spur_req = 1'b1;
        @(negedge ui_clk);
        spur_req = 1'b0;
        repeat (2) @(negedge ui_clk);
        check("spur_err",       128'(err),           128'(1));
        check("spur_out_valid", 128'(bus.out_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
